// File: rtl/controller_pkg.sv
// rtl/controller_pkg.sv - shared state encoding and display codes for the stage sequencer
package controller_pkg;

  localparam logic [2:0] ST_RESET       = 3'd0;
  localparam logic [2:0] ST_CLEAR_START = 3'd1;
  localparam logic [2:0] ST_CLEAR_WAIT  = 3'd2;
  localparam logic [2:0] ST_IDLE        = 3'd3;
  localparam logic [2:0] ST_STAGE_START = 3'd4;
  localparam logic [2:0] ST_STAGE_WAIT  = 3'd5;
  localparam logic [2:0] ST_DISPLAY     = 3'd6;
  localparam logic [2:0] ST_ERROR       = 3'd7;

  localparam int BLANK_CODE = 10;
  localparam int ERROR_CODE = 11;
  localparam int MAX_STAGES = 8;

  typedef enum logic [2:0] {
    S_RESET       = ST_RESET,
    S_CLEAR_START = ST_CLEAR_START,
    S_CLEAR_WAIT  = ST_CLEAR_WAIT,
    S_IDLE        = ST_IDLE,
    S_STAGE_START = ST_STAGE_START,
    S_STAGE_WAIT  = ST_STAGE_WAIT,
    S_DISPLAY     = ST_DISPLAY,
    S_ERROR       = ST_ERROR
  } state_t;

endpackage

// File: rtl/stage_watchdog.sv
// rtl/stage_watchdog.sv - per-stage timeout counter; flags the last allowed wait cycle
module stage_watchdog #(
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int TIMER_W        = 21
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clear,
  input  logic run,
  output logic timeout
);

  // TIMEOUT_CYCLES of zero disables the watchdog entirely
  localparam bit ACTIVE = (TIMEOUT_CYCLES != 0);
  localparam logic [TIMER_W-1:0] LAST = ACTIVE ? TIMER_W'(TIMEOUT_CYCLES - 1) : '0;

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (en) begin
      if (clear) begin
        count <= '0;
      end else if (run && ACTIVE) begin
        count <= count + 1'b1;
      end
    end
  end

  assign timeout = ACTIVE && run && (count == LAST);

endmodule

// File: rtl/stage_sequencer.sv
// rtl/stage_sequencer.sv - master controller: clear display, wait for a press, run the
// processing stages in turn and show the latched result or a timeout error
module stage_sequencer
  import controller_pkg::*;
#(
  parameter int NUM_STAGES     = 2,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int TIMER_W        = 21,
  parameter int DIGIT_W        = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  button,
  input  logic                  painter_ready,
  output logic                  clear_display,
  output logic                  reset_display,
  output logic                  enable_graphics,
  output logic [NUM_STAGES-1:0] stage_start,
  output logic [NUM_STAGES-1:0] stage_enable,
  output logic [NUM_STAGES-1:0] stage_reset,
  input  logic [NUM_STAGES-1:0] stage_done,
  input  logic [DIGIT_W-1:0]    predicted_digit,
  output logic [DIGIT_W-1:0]    output_digit,
  output logic                  busy,
  output logic                  error,
  output logic [2:0]            error_stage
);

  state_t              state, state_next;
  logic [2:0]          idx, idx_next;
  logic [DIGIT_W-1:0]  result, result_next;
  logic [2:0]          error_stage_next;
  logic                button_q;
  logic                press;
  logic                done_active;
  logic                last_stage;
  logic                timeout;
  logic [NUM_STAGES-1:0] stage_sel;

  assign press       = button & ~button_q;
  assign stage_sel   = NUM_STAGES'(1) << idx;
  // only the active stage's done bit is ever looked at
  assign done_active = |(stage_done & stage_sel);
  assign last_stage  = (idx == 3'(NUM_STAGES - 1));

  stage_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TIMER_W       (TIMER_W)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .clear  (state == S_STAGE_START),
    .run    (state == S_STAGE_WAIT),
    .timeout(timeout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_RESET;
      idx         <= '0;
      result      <= '0;
      button_q    <= 1'b0;
      error_stage <= '0;
    end else if (en) begin
      state       <= state_next;
      idx         <= idx_next;
      result      <= result_next;
      button_q    <= button;
      error_stage <= error_stage_next;
    end
  end

  always_comb begin
    state_next       = state;
    idx_next         = idx;
    result_next      = result;
    error_stage_next = error_stage;
    case (state)
      S_RESET:       state_next = S_CLEAR_WAIT;
      S_CLEAR_START: state_next = S_CLEAR_WAIT;
      S_CLEAR_WAIT:  if (painter_ready) state_next = S_IDLE;
      S_IDLE: begin
        if (press) begin
          state_next = S_STAGE_START;
          idx_next   = '0;
        end
      end
      S_STAGE_START: state_next = S_STAGE_WAIT;
      S_STAGE_WAIT: begin
        // done takes precedence over a coincident timeout
        if (done_active) begin
          if (last_stage) begin
            result_next = predicted_digit;
            state_next  = S_DISPLAY;
          end else begin
            idx_next   = idx + 3'd1;
            state_next = S_STAGE_START;
          end
        end else if (timeout) begin
          error_stage_next = idx;
          state_next       = S_ERROR;
        end
      end
      S_DISPLAY:     if (press) state_next = S_CLEAR_START;
      S_ERROR:       if (press) state_next = S_CLEAR_START;
      default:       state_next = S_RESET;
    endcase
  end

  always_comb begin
    clear_display   = 1'b0;
    reset_display   = 1'b0;
    enable_graphics = 1'b0;
    stage_start     = '0;
    stage_enable    = '0;
    stage_reset     = '0;
    output_digit    = DIGIT_W'(BLANK_CODE);
    busy            = 1'b0;
    error           = 1'b0;
    case (state)
      S_RESET: begin
        clear_display = 1'b1;
        reset_display = 1'b1;
        stage_reset   = '1;
      end
      S_CLEAR_START: begin
        clear_display   = 1'b1;
        enable_graphics = 1'b1;
        stage_reset     = '1;
      end
      S_CLEAR_WAIT: begin
        enable_graphics = 1'b1;
        stage_reset     = '1;
      end
      S_IDLE:        enable_graphics = 1'b1;
      S_STAGE_START: begin
        stage_start  = stage_sel;
        stage_enable = stage_sel;
        busy         = 1'b1;
      end
      S_STAGE_WAIT: begin
        stage_enable = stage_sel;
        busy         = 1'b1;
      end
      S_DISPLAY:     output_digit = result;
      S_ERROR: begin
        stage_reset  = '1;
        output_digit = DIGIT_W'(ERROR_CODE);
        error        = 1'b1;
      end
      default: begin
        stage_reset = '1;
      end
    endcase
  end

endmodule

// File: tb/tb_stage_sequencer.sv
// tb/tb_stage_sequencer.sv - directed and randomized checks of stage_sequencer against a behavioural model
module tb_stage_sequencer;

  localparam int N  = 3;
  localparam int T  = 16;
  localparam int TW = 5;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          en = 1'b1;
  logic          button = 1'b0;
  logic          painter_ready = 1'b0;
  logic [N-1:0]  stage_done = '0;
  logic [DW-1:0] predicted_digit = '0;
  logic          clear_display, reset_display, enable_graphics;
  logic [N-1:0]  stage_start, stage_enable, stage_reset;
  logic [DW-1:0] output_digit;
  logic          busy, error;
  logic [2:0]    error_stage;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 0;
  bit rec_on = 0;
  logic [N-1:0] start_log[$];

  always #5 clk = ~clk;

  stage_sequencer #(
    .NUM_STAGES(N), .TIMEOUT_CYCLES(T), .TIMER_W(TW), .DIGIT_W(DW)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .button(button), .painter_ready(painter_ready),
    .clear_display(clear_display), .reset_display(reset_display),
    .enable_graphics(enable_graphics), .stage_start(stage_start),
    .stage_enable(stage_enable), .stage_reset(stage_reset), .stage_done(stage_done),
    .predicted_digit(predicted_digit), .output_digit(output_digit), .busy(busy),
    .error(error), .error_stage(error_stage)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model phases: what the controller is doing, in plain words
  localparam int P_POWERUP = 0, P_WIPE = 1, P_PAINT_WAIT = 2, P_READY = 3;
  localparam int P_KICK = 4, P_RUNNING = 5, P_SHOW = 6, P_FAULT = 7;

  int m_phase, m_idx, m_result, m_err, m_wait;
  bit m_btn;

  always @(posedge clk) begin : model
    int ph, ix, res, er, wt;
    bit pr;
    ph = m_phase; ix = m_idx; res = m_result; er = m_err; wt = m_wait;
    if (reset) begin
      ph = P_POWERUP; ix = 0; res = 0; er = 0; wt = 0;
      m_btn <= 1'b0;
    end else if (en) begin
      pr = button && !m_btn;
      m_btn <= button;
      if (ph == P_POWERUP || ph == P_WIPE) ph = P_PAINT_WAIT;
      else if (ph == P_PAINT_WAIT) begin
        if (painter_ready) ph = P_READY;
      end else if (ph == P_READY) begin
        if (pr) begin ph = P_KICK; ix = 0; end
      end else if (ph == P_KICK) begin
        ph = P_RUNNING; wt = 0;
      end else if (ph == P_RUNNING) begin
        if (stage_done[ix]) begin
          if (ix < N - 1) begin ix++; ph = P_KICK; end
          else begin res = int'(predicted_digit); ph = P_SHOW; end
        end else if (wt == T - 1) begin
          er = ix; ph = P_FAULT;
        end else wt++;
      end else if (pr) ph = P_WIPE;
    end
    m_phase <= ph; m_idx <= ix; m_result <= res; m_err <= er; m_wait <= wt;
  end

  always @(negedge clk) begin : compare
    logic [N-1:0] sel;
    if (cmp_on) begin
      sel = (m_phase == P_KICK || m_phase == P_RUNNING) ? (N'(1) << m_idx) : '0;
      chk("clear_display", clear_display, m_phase == P_POWERUP || m_phase == P_WIPE);
      chk("reset_display", reset_display, m_phase == P_POWERUP);
      chk("enable_graphics", enable_graphics,
          m_phase == P_WIPE || m_phase == P_PAINT_WAIT || m_phase == P_READY);
      chk("stage_reset", stage_reset, (m_phase == P_POWERUP || m_phase == P_WIPE ||
          m_phase == P_PAINT_WAIT || m_phase == P_FAULT) ? {N{1'b1}} : '0);
      chk("stage_enable", stage_enable, sel);
      chk("stage_start", stage_start, (m_phase == P_KICK) ? sel : '0);
      chk("output_digit", output_digit,
          (m_phase == P_SHOW) ? m_result : (m_phase == P_FAULT) ? 11 : 10);
      chk("busy", busy, m_phase == P_KICK || m_phase == P_RUNNING);
      chk("error", error, m_phase == P_FAULT);
      chk("error_stage", error_stage, m_err);
      if (rec_on && stage_start != '0) start_log.push_back(stage_start);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic press();
    button = 1'b1;
    step();
    button = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      if (enable_graphics && stage_reset == '0 && !busy) begin ok = 1; break; end
      step();
    end
    if (!ok) chk("wait_idle_bound", 0, 1);
  endtask

  task automatic wait_stage_wait(input int k);
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      if (busy && stage_enable[k] && !stage_start[k]) begin ok = 1; break; end
      step();
    end
    if (!ok) chk("wait_stage_bound", k, 99);
  endtask

  // Assert done for stage k during the d-th cycle of its wait
  task automatic run_stage(input int k, input int d);
    wait_stage_wait(k);
    steps(d - 1);
    stage_done[k] = 1'b1;
    step();
    stage_done[k] = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1;
    step();
    cmp_on = 1;
    chk("rst_clear", clear_display, 1);
    chk("rst_reset_display", reset_display, 1);
    chk("rst_digit", output_digit, 10);
    chk("rst_stage_reset", stage_reset, 7);
    chk("rst_busy", busy, 0);
    steps(2);
    reset = 1'b0;
    steps(5);
    painter_ready = 1'b1;
    wait_idle();
    chk("idle_stage_reset", stage_reset, 0);
    chk("idle_gfx", enable_graphics, 1);

    // Full three-stage run
    predicted_digit = 4'd7;
    start_log.delete();
    rec_on = 1;
    press();
    run_stage(0, 4);
    run_stage(1, 7);
    run_stage(2, 2);
    rec_on = 0;
    chk("display_digit", output_digit, 7);
    chk("display_busy", busy, 0);
    chk("start_count", start_log.size(), 3);
    for (int i = 0; i < start_log.size(); i++) chk("start_order", start_log[i], 1 << i);
    predicted_digit = 4'd3;
    step();
    chk("display_held", output_digit, 7);

    // Held button gives one start; stage 0 then times out
    press();
    chk("wipe_from_display", clear_display, 1);
    wait_idle();
    start_log.delete();
    rec_on = 1;
    button = 1'b1;
    steps(100);
    button = 1'b0;
    rec_on = 0;
    chk("held_pulses", start_log.size(), 1);
    chk("held_error", error, 1);
    chk("held_error_stage", error_stage, 0);
    step();
    press();
    chk("wipe_from_error", clear_display, 1);
    wait_idle();

    // Stage 1 never finishes; a second press during the wait is ignored
    press();
    run_stage(0, 3);
    wait_stage_wait(1);
    n = 0;
    while (!error && n < 100) begin
      if (n == 3) button = 1'b1;
      if (n == 4) button = 1'b0;
      step();
      n++;
    end
    chk("timeout_latency", n, 16);
    chk("timeout_stage", error_stage, 1);
    chk("timeout_digit", output_digit, 11);
    chk("timeout_stage_reset", stage_reset, 7);
    press();
    chk("wipe_after_timeout", clear_display, 1);
    wait_idle();

    // Done on the same cycle as the timeout
    press();
    wait_stage_wait(0);
    steps(T - 1);
    stage_done[0] = 1'b1;
    step();
    stage_done[0] = 1'b0;
    chk("coinc_error", error, 0);
    chk("coinc_start", stage_start, 2);

    // Freeze for 10 cycles mid-wait
    wait_stage_wait(1);
    n = 0;
    while (!error && n < 200) begin
      if (n == 5) en = 1'b0;
      if (n == 15) en = 1'b1;
      step();
      n++;
    end
    chk("frozen_latency", n, 26);
    press();
    wait_idle();

    // Reset while displaying
    predicted_digit = 4'd9;
    press();
    run_stage(0, 1);
    run_stage(1, 1);
    run_stage(2, 1);
    chk("display_nine", output_digit, 9);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_clear", clear_display, 1);
    chk("midrst_reset_display", reset_display, 1);
    chk("midrst_digit", output_digit, 10);
    chk("midrst_stage_reset", stage_reset, 7);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      en              = ($urandom_range(0, 19) != 0);
      reset           = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 5) == 0) button = ~button;
      painter_ready   = ($urandom_range(0, 3) == 0);
      for (int b = 0; b < N; b++) stage_done[b] = ($urandom_range(0, 11) == 0);
      predicted_digit = DW'($urandom);
      step();
    end
    reset = 1'b0;
    step();
    cmp_on = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stage_sequencer.md
# stage_sequencer

Parametrised master controller for the digit-recognition datapath. It runs a clear-display phase, then waits in idle for a button press. It then starts NUM_STAGES processing engines in turn over start/enable/reset/done handshakes and shows the latched result on the seven-segment display. It sits at top level between the painter/graphics subsystem, the processing chain (average pooling, neural network, or any later stages) and the seven-segment decoder. Compared with a fixed two-stage controller, it adds button edge detection, a per-stage timeout watchdog with an error state, and a registered result.

## Interface
- NUM_STAGES, 2, number of chained processing stages (1..8)
- TIMEOUT_CYCLES, 1048576, maximum STAGE_WAIT cycles per stage; 0 disables the watchdog
- TIMER_W, 21, watchdog counter width; must satisfy 2^TIMER_W > TIMEOUT_CYCLES
- DIGIT_W, 4, result/display code width
- clk  in  1  system clock
- reset  in  1  reset, synchronous and active-high
- en  in  1  global enable; 0 freezes all state
- button  in  1  level user button, already synchronised
- painter_ready  in  1  graphics idle/clear complete
- clear_display  out  1  request to clear the canvas
- reset_display  out  1  graphics reset
- enable_graphics  out  1  graphics/drawing enable
- stage_start  out  NUM_STAGES  one-cycle start pulse, one bit per stage
- stage_enable  out  NUM_STAGES  stage clock enable
- stage_reset  out  NUM_STAGES  stage reset
- stage_done  in  NUM_STAGES  stage completion; sampled only for the active stage
- predicted_digit  in  DIGIT_W  result of the last stage
- output_digit  out  DIGIT_W  code to the seven-segment decoder
- busy  out  1  high in STAGE_START/STAGE_WAIT
- error  out  1  high in ERROR
- error_stage  out  3  index of the stage that timed out; holds until the next error

## Operation
- States: RESET, CLEAR_START, CLEAR_WAIT, IDLE, STAGE_START, STAGE_WAIT, DISPLAY, ERROR. Registered state; Moore outputs decoded from state and stage index.
- Button edge: press = button & ~button_q, where button_q is a 1-bit register updated when en=1. Presses outside IDLE/DISPLAY/ERROR are dropped, not queued.
- Transitions:
  - RESET→CLEAR_WAIT.
  - CLEAR_START→CLEAR_WAIT.
  - CLEAR_WAIT→IDLE on painter_ready.
  - IDLE→STAGE_START on press, with idx=0.
  - STAGE_START→STAGE_WAIT.
  - STAGE_WAIT on stage_done[idx]: if idx<NUM_STAGES-1, idx+1 then STAGE_START; otherwise latch predicted_digit into result, then DISPLAY.
  - STAGE_WAIT→ERROR on timeout, latching error_stage=idx.
  - DISPLAY→CLEAR_START on press.
  - ERROR→CLEAR_START on press.
  - Illegal state→RESET.
- Output decode:
  - clear_display=1 in RESET and CLEAR_START.
  - reset_display=1 in RESET only.
  - enable_graphics=1 in CLEAR_START, CLEAR_WAIT and IDLE.
  - stage_reset: all ones in RESET, CLEAR_START, CLEAR_WAIT and ERROR; zero otherwise.
  - stage_enable[idx]=1 in STAGE_START/STAGE_WAIT; other bits 0.
  - stage_start[idx]=1 in STAGE_START only.
  - output_digit=result in DISPLAY, 11 (ERROR_CODE) in ERROR, otherwise 10 (BLANK_CODE).
- Watchdog: cleared on entry to STAGE_WAIT and increments each enabled cycle in STAGE_WAIT. Timeout fires when count==TIMEOUT_CYCLES-1 and stage_done[idx]=0. If done and timeout coincide, done wins.

## Timing
- Reset values (cycle after reset is sampled high): state RESET, idx=0, result=0, timer=0, button_q=0, error_stage=0. Outputs: clear_display=1, reset_display=1, enable_graphics=0, stage_start=0, stage_enable=0, stage_reset=all ones, output_digit=10, busy=0, error=0.
- Reset has priority over en. Reset mid-operation reaches the RESET state on the next edge with no handshake to the stages; stage_reset covers them.
- Press in IDLE at cycle t → stage_start[0] high during t+1 only.
- stage_done[k] sampled high at t → stage_start[k+1] at t+1. For the last stage, output_digit=result from t+1.
- Timeout: ERROR is entered exactly TIMEOUT_CYCLES cycles after entry to STAGE_WAIT.
- en=0: state, idx, timer, button_q and result hold; outputs stay constant.
- stage_done of non-active stages and painter_ready outside CLEAR_WAIT are ignored.

## Structure
- Package controller_pkg: state encoding localparams (3 bits), BLANK_CODE=10, ERROR_CODE=11, MAX_STAGES=8.
- One sub-module, stage_watchdog (clk, reset, en, clear, run, timeout; parameters TIMEOUT_CYCLES and TIMER_W). The FSM, edge detector and result register live in stage_sequencer.

## Test plan
- Reset for 3 cycles; painter_ready=1 five cycles later → IDLE; clear_display high only during RESET; output_digit=10; stage_reset=all ones until IDLE.
- NUM_STAGES=3, press; stage_done after 4, 7 and 2 cycles; predicted_digit=7 → exactly one stage_start pulse per stage in order 0,1,2; DISPLAY with output_digit=7; busy low.
- Button held high for 100 cycles in IDLE → a single stage_start[0] pulse. A second press during STAGE_WAIT is ignored.
- TIMEOUT_CYCLES=16, stage 1 never done → ERROR 16 cycles after STAGE_WAIT entry; error=1, error_stage=1, output_digit=11, stage_reset all ones. Press → CLEAR_START with clear_display pulse.
- stage_done[0] asserted on the same cycle as the timeout → advance to stage 1, no error.
- en=0 for 10 cycles mid STAGE_WAIT → timer and outputs frozen, and timeout is delayed by 10 cycles. Reset asserted in DISPLAY → RESET values on the next edge.
